// File: rtl/maq_control_modos.sv
// maq_control_modos: general control FSM for the RTC clock/alarm/chronometer
// system. Arbitrates N_MODOS programming requests (index 0 highest priority),
// drives the mode-select bus (Control) and the RTC write handshake, raises
// alarm/chronometer-expiry events and emits a sync pulse on each state change.
// Optional feature macro: MCG_TIMEOUT_EN (abandons PROGRAMA/ESCRITURA after
// TIMEOUT cycles without confirm/ack and pulses 'timeout').
module maq_control_modos #(
    parameter int N_MODOS   = 3,
    parameter int CRONO_IDX = 2,
    parameter int ALARMA_W  = 24,
    parameter int TIMEOUT   = 1000,
    parameter int CTRL_W    = 2
) (
    input  logic                reloj,
    input  logic                resetM,
    input  logic [N_MODOS-1:0]  req_prog,
    input  logic                F_H,
    input  logic                R_RTC,
    input  logic                A_A,
    input  logic [ALARMA_W-1:0] alarma,
    input  logic [ALARMA_W-1:0] tiempo,
    input  logic                alarma_arm,
    input  logic                crono_fin,
    output logic [CTRL_W-1:0]   Control,
    output logic                act_crono,
    output logic                alarma_on,
    output logic                timeout,
    output logic [2:0]          Status3bit,
    output logic                sync
);

    typedef enum logic [2:0] {
        INICIO    = 3'd0,
        LECTURA   = 3'd1,
        PROGRAMA  = 3'd2,
        ESCRITURA = 3'd3,
        ALARMA    = 3'd4
    } estado_t;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    estado_t             state_reg, state_next;
    logic [N_MODOS-1:0]  req_q_reg;
    logic [CTRL_W-1:0]   idx_reg, idx_next;
    logic [CTRL_W-1:0]   control_reg, control_next;
    logic                act_crono_reg, act_crono_next;
    logic                alarma_on_reg;
    logic                sync_reg;
    logic                disparo_reg, disparo_next;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [N_MODOS-1:0]  edge_vec;
    logic                edge_any;
    logic [CTRL_W-1:0]   edge_idx;
    logic                hora_match;
    logic                alarm_by_time;
    logic                alarm_by_crono;
    logic                crono_start;
    logic                disparo_set;
    logic                prog_or_write_next;

    // Rising edge of each request line; edges are only acted on in LECTURA
    generate
        for (genvar gi = 0; gi < N_MODOS; gi++) begin : g_edge
            assign edge_vec[gi] = req_prog[gi] & ~req_q_reg[gi];
        end
    endgenerate

    assign edge_any = |edge_vec;

    // Lowest set index wins: scan from the top so the lowest index is written last
    always_comb begin
        edge_idx = '0;
        for (int i = N_MODOS - 1; i >= 0; i--) begin
            if (edge_vec[i]) begin
                edge_idx = CTRL_W'(i);
            end
        end
    end

    assign hora_match     = (tiempo == alarma);
    // disparo blocks re-ringing on the same match after the user acknowledged it
    assign alarm_by_time  = alarma_arm & hora_match & ~disparo_reg;
    assign alarm_by_crono = act_crono_reg & crono_fin;

`ifdef MCG_TIMEOUT_EN
    // ------------------------------------------------------------------
    // Abandon timer for PROGRAMA / ESCRITURA
    // ------------------------------------------------------------------
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] timer_reg, timer_next;
    logic          expire;
    logic          abandon;
    logic          timeout_reg;

    assign expire = ((state_reg == PROGRAMA) || (state_reg == ESCRITURA)) &&
                    (timer_reg == TW'(TIMEOUT - 1));

    // Timer restarts on every state entry and only runs while waiting
    always_comb begin
        timer_next = '0;
        if ((state_next == state_reg) &&
            ((state_reg == PROGRAMA) || (state_reg == ESCRITURA))) begin
            timer_next = timer_reg + TW'(1);
        end
    end

    // Timer and one-cycle abandon pulse registers
    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            timer_reg   <= '0;
            timeout_reg <= 1'b0;
        end else begin
            timer_reg   <= timer_next;
            timeout_reg <= abandon;
        end
    end

    assign timeout = timeout_reg;
`else
    assign timeout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state and side-effect decode
    // ------------------------------------------------------------------
    // Next-state logic with request latching, chronometer start and alarm cause
    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        crono_start = 1'b0;
        disparo_set = 1'b0;
`ifdef MCG_TIMEOUT_EN
        abandon     = 1'b0;
`endif
        case (state_reg)
            INICIO: begin
                state_next = LECTURA;
            end
            LECTURA: begin
                // Alarm outranks a request; a simultaneous request edge is lost
                if (alarm_by_time || alarm_by_crono) begin
                    state_next  = ALARMA;
                    disparo_set = alarm_by_time;
                end else if (edge_any) begin
                    state_next = PROGRAMA;
                    idx_next   = edge_idx;
                end
            end
            PROGRAMA: begin
                // Confirm wins over a coincident timer expiry
                if (F_H) begin
                    if (idx_reg == CTRL_W'(CRONO_IDX)) begin
                        state_next  = LECTURA;
                        crono_start = 1'b1;
                    end else begin
                        state_next = ESCRITURA;
                    end
                end
`ifdef MCG_TIMEOUT_EN
                else if (expire) begin
                    state_next = LECTURA;
                    abandon    = 1'b1;
                end
`endif
            end
            ESCRITURA: begin
                // RTC acknowledge wins over a coincident timer expiry
                if (R_RTC) begin
                    state_next = LECTURA;
                end
`ifdef MCG_TIMEOUT_EN
                else if (expire) begin
                    state_next = LECTURA;
                    abandon    = 1'b1;
                end
`endif
            end
            ALARMA: begin
                if (A_A) begin
                    state_next = LECTURA;
                end
            end
            default: begin
                state_next = LECTURA;
            end
        endcase
    end

    // Registered output values derived from the upcoming state
    always_comb begin
        prog_or_write_next = (state_next == PROGRAMA) || (state_next == ESCRITURA);
        control_next       = prog_or_write_next ? (idx_next + CTRL_W'(1)) : '0;

        // A finished chronometer always stops it, even if a start coincides
        act_crono_next = act_crono_reg;
        if (crono_start) begin
            act_crono_next = 1'b1;
        end
        if (crono_fin) begin
            act_crono_next = 1'b0;
        end

        // Latch ends once the time moves off the alarm value
        disparo_next = disparo_reg;
        if (!hora_match) begin
            disparo_next = 1'b0;
        end else if (disparo_set) begin
            disparo_next = 1'b1;
        end
    end

    // State register and registered outputs
    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            state_reg     <= INICIO;
            req_q_reg     <= '0;
            idx_reg       <= '0;
            control_reg   <= '0;
            act_crono_reg <= 1'b0;
            alarma_on_reg <= 1'b0;
            sync_reg      <= 1'b0;
            disparo_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            req_q_reg     <= req_prog;
            idx_reg       <= idx_next;
            control_reg   <= control_next;
            act_crono_reg <= act_crono_next;
            alarma_on_reg <= (state_next == ALARMA);
            sync_reg      <= (state_next != state_reg);
            disparo_reg   <= disparo_next;
        end
    end

    assign Control    = control_reg;
    assign act_crono  = act_crono_reg;
    assign alarma_on  = alarma_on_reg;
    assign Status3bit = state_reg;
    assign sync       = sync_reg;

endmodule
